// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory fetch bus: word request/ready handshake between the fetch stage and imem.
interface mips_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: holds the PC, fetches one word per FETCH/ISSUE round trip and
// resolves jr/jump/branch redirects when the held instruction is released downstream.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  mips_fetch_unit_if.master       imem,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_offset,
  input  logic                    jump,
  input  logic [25:0]             jump_target,
  input  logic                    jr,
  input  logic [31:0]             jr_addr,
  output logic [31:0]             pc,
  output logic [31:0]             pc_plus4,
  output logic [31:0]             instr,
  output logic                    instr_valid,
  output logic                    addr_err,
  output logic                    fetch_timeout
);

  typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t             state, state_nxt;
  logic [7:0]         wait_cnt;
  logic               req_c;
  logic               capture;
  logic               advance;
  logic [31:0]        next_pc;
  logic signed [31:0] branch_disp;

  assign pc_plus4    = pc + 32'd4;
  assign imem.req    = req_c;
  assign imem.addr   = pc;
  assign branch_disp = $signed({branch_offset[29:0], 2'b00});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_c       = 1'b0;
    instr_valid = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (imem.ready) begin
          capture   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          advance   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Redirect priority: jr > jump > branch > sequential; all arithmetic wraps modulo 2^32.
  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = {jr_addr[31:2], 2'b00};
    else if (jump)
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + $unsigned(branch_disp);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= RESET_PC;
      instr         <= 32'h0;
      wait_cnt      <= 8'd0;
      addr_err      <= 1'b0;
      fetch_timeout <= 1'b0;
    end else begin
      if (capture) begin
        instr    <= imem.rdata;
        wait_cnt <= 8'd0;
      end else if (state == FETCH) begin
        // Saturating wait count; the flag is raised on the cycle the count reaches TIMEOUT.
        if (wait_cnt < TIMEOUT_CNT)
          wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt >= TIMEOUT_CNT - 8'd1)
          fetch_timeout <= 1'b1;
      end
      if (advance) begin
        pc <= next_pc;
        if (jr && (jr_addr[1:0] != 2'b00))
          addr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: stimulus queues expected {pc,instr}; a monitor checks each issue.
module tb_mips_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, jump, jr;
  logic [31:0] branch_offset, jr_addr;
  logic [25:0] jump_target;
  logic [31:0] pc, pc_plus4, instr;
  logic        instr_valid, addr_err, fetch_timeout;
  logic        ready_en;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_pc_q[$];
  logic        prev_valid;

  mips_fetch_unit_if imem ();

  mips_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .imem(imem.master),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
    .addr_err(addr_err), .fetch_timeout(fetch_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  assign imem.ready = ready_en;
  assign imem.rdata = mem_word(imem.addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    @(negedge clk);
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      total++;
      bad++;
      $display("FAIL wait_%s: instr_valid never rose within 60 cycles", tag);
    end
  endtask

  task automatic clear_redirects();
    branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
  endtask

  // Monitor: each new issue must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (exp_pc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got pc %h expected none", pc);
        end else begin
          logic [31:0] e;
          e = exp_pc_q.pop_front();
          chk("issue_pc", pc, e);
          chk("issue_instr", instr, mem_word(e));
          chk("issue_pc_plus4", pc_plus4, e + 32'd4);
        end
      end
      prev_valid = instr_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ready_en = 1'b1; stall = 1'b0;
    clear_redirects();
    branch_offset = 32'h0; jr_addr = 32'h0; jump_target = 26'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_flags", {30'h0, addr_err, fetch_timeout}, 32'h0);
    chk("rst_req", {31'h0, imem.req}, 32'h1);

    exp_pc_q.push_back(32'h0);
    exp_pc_q.push_back(32'h4);
    exp_pc_q.push_back(32'h8);
    exp_pc_q.push_back(32'hC);
    @(negedge clk) reset = 1'b0;

    // Sequential run; valid must alternate with fetch cycles
    wait_issue("seq0");
    @(negedge clk);
    chk("seq_valid_gap", {31'h0, instr_valid}, 32'h0);
    wait_issue("seq4");
    wait_issue("seq8");
    wait_issue("seqC");
    jr = 1'b1; jr_addr = 32'h0000_0100;
    exp_pc_q.push_back(32'h100);
    @(posedge clk); #1 clear_redirects();

    wait_issue("p100a");
    branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
    exp_pc_q.push_back(32'h0FC);
    @(posedge clk); #1 clear_redirects();
    wait_issue("pFC");
    exp_pc_q.push_back(32'h100);
    wait_issue("p100b");
    branch_taken = 1'b1; branch_offset = 32'h0000_0010;
    exp_pc_q.push_back(32'h144);
    @(posedge clk); #1 clear_redirects();

    wait_issue("p144");
    jr = 1'b1; jr_addr = 32'h4000_0000;
    exp_pc_q.push_back(32'h4000_0000);
    @(posedge clk); #1 clear_redirects();
    chk("aligned_jr_no_err", {31'h0, addr_err}, 32'h0);

    wait_issue("p4000");
    jump = 1'b1; jump_target = 26'h000_0010; branch_taken = 1'b1; branch_offset = 32'h0000_0100;
    exp_pc_q.push_back(32'h4000_0040);
    @(posedge clk); #1 clear_redirects();

    wait_issue("p4040");
    jr = 1'b1; jr_addr = 32'h0000_2002; jump = 1'b1; branch_taken = 1'b1;
    exp_pc_q.push_back(32'h0000_2000);
    @(posedge clk); #1 clear_redirects();
    chk("addr_err_set", {31'h0, addr_err}, 32'h1);

    // Memory stalls for 20 cycles while fetching 0x2004
    wait_issue("p2000");
    ready_en = 1'b0;
    exp_pc_q.push_back(32'h0000_2004);
    @(posedge clk);
    repeat (14) @(posedge clk);
    #1;
    chk("timeout_before", {31'h0, fetch_timeout}, 32'h0);
    @(posedge clk); #1;
    chk("timeout_after", {31'h0, fetch_timeout}, 32'h1);
    chk("timeout_req", {31'h0, imem.req}, 32'h1);
    chk("timeout_addr", imem.addr, 32'h0000_2004);
    repeat (5) @(posedge clk);
    #1;
    chk("timeout_sticky", {31'h0, fetch_timeout}, 32'h1);
    ready_en = 1'b1;

    wait_issue("p2004");
    stall = 1'b1; branch_taken = 1'b1; branch_offset = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_pc", pc, 32'h0000_2004);
      chk("stall_instr", instr, mem_word(32'h0000_2004));
      chk("stall_req", {31'h0, imem.req}, 32'h0);
      branch_taken = ~branch_taken;
    end
    stall = 1'b0; clear_redirects();
    exp_pc_q.push_back(32'h0000_2008);

    wait_issue("p2008");
    ready_en = 1'b0;
    @(negedge clk);
    chk("midfetch_addr", imem.addr, 32'h0000_200C);
    chk("addr_err_sticky", {31'h0, addr_err}, 32'h1);
    reset = 1'b1; ready_en = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("async_rst_flags", {30'h0, addr_err, fetch_timeout}, 32'h0);
    @(posedge clk); #1;
    chk("rst_ready_ignored", pc, 32'h0);
    exp_pc_q.push_back(32'h0);
    @(negedge clk) reset = 1'b0;
    #1 chk("post_rst_req_addr", imem.addr, 32'h0);
    wait_issue("post_rst");
    @(negedge clk);
    chk("queue_drained", exp_pc_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
